// File: rtl/core_regfile_banked_pkg.sv
// Shared constants and types for the banked core register file.
// Holds the special-register offsets, the reset constants and the sequencer state enum.
package core_reg_pkg;
  // Special registers sit at the top of the index space, counted down from NUM_REGS
  localparam int SP_OFS = 3;
  localparam int LR_OFS = 2;
  localparam int PC_OFS = 1;

  localparam int APSR_N = 3;
  localparam int APSR_Z = 2;
  localparam int APSR_C = 1;
  localparam int APSR_V = 0;

  localparam logic [5:0]  IPSR_RST   = 6'h3F;
  localparam logic [63:0] LR_RST_ALL = '1;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_EMIT,
    SEQ_DONE
  } seq_state_e;
endpackage

// File: rtl/core_regfile_banked_seq.sv
// Register-list sequencer: emits one register index per accepted beat, lowest index first.
// Latches the list and its popcount on start; start is ignored while busy.
module reg_list_seq
  import core_reg_pkg::*;
#(
  parameter  int NUM_REGS = 16,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NUM_REGS-1:0] list,
  input  logic                ready,
  output logic                busy,
  output logic                valid,
  output logic                done,
  output logic [ADDR_W-1:0]   idx,
  output logic [ADDR_W:0]     count
);
  seq_state_e          state, state_nx;
  logic [NUM_REGS-1:0] rem, rem_nx, rem_clr;
  logic [ADDR_W:0]     cnt, cnt_nx, list_pop;
  logic [ADDR_W-1:0]   low_idx;

  always_comb begin
    low_idx = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--)
      if (rem[i]) low_idx = ADDR_W'(i);
  end

  always_comb begin
    list_pop = '0;
    for (int i = 0; i < NUM_REGS; i++)
      list_pop = list_pop + (ADDR_W+1)'(list[i]);
  end

  // x & (x-1) drops the lowest set bit
  assign rem_clr = rem & (rem - NUM_REGS'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEQ_IDLE;
      rem   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      rem   <= rem_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    rem_nx   = rem;
    cnt_nx   = cnt;
    case (state)
      SEQ_IDLE: if (start) begin
        rem_nx   = list;
        cnt_nx   = list_pop;
        state_nx = (list == '0) ? SEQ_DONE : SEQ_EMIT;
      end
      SEQ_EMIT: if (ready) begin
        rem_nx = rem_clr;
        if (rem_clr == '0) state_nx = SEQ_DONE;
      end
      SEQ_DONE: state_nx = SEQ_IDLE;
      default:  state_nx = SEQ_IDLE;
    endcase
  end

  assign valid = (state == SEQ_EMIT);
  assign done  = (state == SEQ_DONE);
  assign busy  = valid | done;
  assign idx   = valid ? low_idx : '0;
  assign count = cnt;
endmodule

// File: rtl/core_regfile_banked.sv
// Core register file: dual write ports, banked MSP/PSP, status regs and a PUSH/STM list sequencer.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module core_regfile_banked
  import core_reg_pkg::*;
#(
  parameter  int                DATA_W   = 32,
  parameter  int                NUM_REGS = 16,
  parameter  int                NUM_RD   = 3,
  parameter  logic [DATA_W-1:0] LR_RST   = LR_RST_ALL[DATA_W-1:0],
  parameter  logic [DATA_W-1:0] SP_RST   = '0,
  localparam int                ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wa_en,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     pc_ld,
  input  logic [DATA_W-1:0]        pc_w,
  output logic [DATA_W-1:0]        r_pc,
  output logic [DATA_W-1:0]        r_sp,
  input  logic                     sp_sel,
  input  logic                     apsr_ld,
  input  logic [3:0]               apsr_w,
  input  logic                     ipsr_ld,
  input  logic [5:0]               ipsr_w,
  input  logic                     pm_ld,
  input  logic                     pm_w,
  output logic [3:0]               r_apsr,
  output logic [5:0]               r_ipsr,
  output logic                     r_pm,
  input  logic                     seq_start,
  input  logic [NUM_REGS-1:0]      seq_list,
  output logic                     seq_busy,
  output logic                     seq_valid,
  output logic                     seq_done,
  input  logic                     seq_ready,
  output logic [ADDR_W-1:0]        seq_idx,
  output logic [DATA_W-1:0]        seq_data,
  output logic [ADDR_W:0]          seq_count
);
  localparam logic [ADDR_W-1:0] SP_A = ADDR_W'(NUM_REGS - SP_OFS);
  localparam logic [ADDR_W-1:0] LR_A = ADDR_W'(NUM_REGS - LR_OFS);
  localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(NUM_REGS - PC_OFS);

  // regs[SP_A] is never written; the SP slot is served by the banks
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [DATA_W-1:0]               msp, psp, sp_act, sp_wr_val;
  logic                            sp_wr_en;
  logic [NUM_RD:0][ADDR_W-1:0]     q_a;
  logic [NUM_RD:0][DATA_W-1:0]     q_d;

  assign sp_act = sp_sel ? psp : msp;

  always_comb begin
    sp_wr_en  = 1'b0;
    sp_wr_val = '0;
    if (wb_en && wb_addr == SP_A) begin
      sp_wr_en  = 1'b1;
      sp_wr_val = {wb_data[DATA_W-1:2], 2'b00};
    end else if (wa_en && wa_addr == SP_A) begin
      sp_wr_en  = 1'b1;
      sp_wr_val = {wa_data[DATA_W-1:2], 2'b00};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs       <= '0;
      regs[LR_A] <= LR_RST;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (ADDR_W'(i) == PC_A && pc_ld)
          regs[i] <= pc_w;
        else if (ADDR_W'(i) != SP_A) begin
          if (wb_en && wb_addr == ADDR_W'(i))      regs[i] <= wb_data;
          else if (wa_en && wa_addr == ADDR_W'(i)) regs[i] <= wa_data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msp <= SP_RST;
      psp <= SP_RST;
    end else if (sp_wr_en) begin
      if (sp_sel) psp <= sp_wr_val;
      else        msp <= sp_wr_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_apsr <= '0;
      r_ipsr <= IPSR_RST;
      r_pm   <= 1'b0;
    end else begin
      if (apsr_ld) r_apsr <= apsr_w;
      if (ipsr_ld) r_ipsr <= ipsr_w;
      if (pm_ld)   r_pm   <= pm_w;
    end
  end

  // The sequencer is an extra read port sharing the same mux
  assign q_a = {seq_idx, rd_addr};

  always_comb begin
    for (int k = 0; k <= NUM_RD; k++) begin
      q_d[k] = (q_a[k] == SP_A) ? sp_act : regs[q_a[k]];
`ifdef REGFILE_BYPASS_EN
      if (q_a[k] == PC_A && pc_ld)               q_d[k] = pc_w;
      else if (q_a[k] == SP_A) begin
        if (sp_wr_en)                            q_d[k] = sp_wr_val;
      end
      else if (wb_en && wb_addr == q_a[k])       q_d[k] = wb_data;
      else if (wa_en && wa_addr == q_a[k])       q_d[k] = wa_data;
`endif
    end
  end

  assign rd_data  = q_d[NUM_RD-1:0];
  assign seq_data = seq_valid ? q_d[NUM_RD] : '0;
  assign r_pc     = regs[PC_A];
  assign r_sp     = sp_act;

  reg_list_seq #(.NUM_REGS(NUM_REGS)) u_seq (
    .clk   (clk),
    .rst   (rst),
    .start (seq_start),
    .list  (seq_list),
    .ready (seq_ready),
    .busy  (seq_busy),
    .valid (seq_valid),
    .done  (seq_done),
    .idx   (seq_idx),
    .count (seq_count)
  );
endmodule

// File: tb/tb_core_regfile_banked.sv
// Randomized self-checking bench for core_regfile_banked against an array-based register model.
// Inputs change 1ns after the rising edge; outputs are sampled mid-cycle.
module tb_core_regfile_banked;
  localparam int DW = 32, NR = 16, NRD = 3, AW = 4;

  logic             clk = 1'b0, rst;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic wa_en, wb_en, pc_ld, sp_sel, apsr_ld, ipsr_ld, pm_ld, pm_w;
  logic [AW-1:0] wa_addr, wb_addr;
  logic [DW-1:0] wa_data, wb_data, pc_w, r_pc, r_sp, seq_data;
  logic [3:0] apsr_w, r_apsr;
  logic [5:0] ipsr_w, r_ipsr;
  logic r_pm, seq_start, seq_busy, seq_valid, seq_done, seq_ready;
  logic [NR-1:0] seq_list;
  logic [AW-1:0] seq_idx;
  logic [AW:0]   seq_count;

  core_regfile_banked dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .pc_ld(pc_ld), .pc_w(pc_w), .r_pc(r_pc), .r_sp(r_sp), .sp_sel(sp_sel),
    .apsr_ld(apsr_ld), .apsr_w(apsr_w), .ipsr_ld(ipsr_ld), .ipsr_w(ipsr_w),
    .pm_ld(pm_ld), .pm_w(pm_w), .r_apsr(r_apsr), .r_ipsr(r_ipsr), .r_pm(r_pm),
    .seq_start(seq_start), .seq_list(seq_list), .seq_busy(seq_busy),
    .seq_valid(seq_valid), .seq_done(seq_done), .seq_ready(seq_ready),
    .seq_idx(seq_idx), .seq_data(seq_data), .seq_count(seq_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  // Architectural model: plain array of 16 registers, SP slot replaced by two banks
  logic [DW-1:0] m_gpr [NR];
  logic [DW-1:0] m_sp  [2];
  logic [3:0]    m_apsr;
  logic [5:0]    m_ipsr;
  logic          m_pm;

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_gpr[i] = '0;
    m_gpr[14] = 32'hFFFF_FFFF;
    m_sp[0] = '0; m_sp[1] = '0;
    m_apsr = '0; m_ipsr = 6'h3F; m_pm = 1'b0;
  endtask

  function automatic logic [DW-1:0] m_read(input int a);
    return (a == 13) ? m_sp[sp_sel] : m_gpr[a];
  endfunction

  function automatic logic [DW-1:0] m_expect(input int a);
`ifdef REGFILE_BYPASS_EN
    if (a == 15 && pc_ld) return pc_w;
    if (wb_en && int'(wb_addr) == a) return (a == 13) ? {wb_data[31:2], 2'b00} : wb_data;
    if (wa_en && int'(wa_addr) == a) return (a == 13) ? {wa_data[31:2], 2'b00} : wa_data;
`endif
    return m_read(a);
  endfunction

  task automatic m_wr(input int a, input logic [DW-1:0] d);
    if (a == 13) m_sp[sp_sel] = {d[31:2], 2'b00};
    else         m_gpr[a] = d;
  endtask

  // Later writes override earlier ones: A, then B, then the dedicated PC load
  task automatic model_update();
    if (wa_en) m_wr(int'(wa_addr), wa_data);
    if (wb_en) m_wr(int'(wb_addr), wb_data);
    if (pc_ld) m_gpr[15] = pc_w;
    if (apsr_ld) m_apsr = apsr_w;
    if (ipsr_ld) m_ipsr = ipsr_w;
    if (pm_ld)   m_pm   = pm_w;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_update();
    #1;
  endtask

  task automatic idle();
    wa_en = 0; wa_addr = 0; wa_data = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
    pc_ld = 0; pc_w = 0; apsr_ld = 0; apsr_w = 0; ipsr_ld = 0; ipsr_w = 0;
    pm_ld = 0; pm_w = 0;
  endtask

  function automatic logic [DW-1:0] rdp(input int k);
    return rd_data[k*DW +: DW];
  endfunction

  task automatic test_reset();
    rst = 1; rd_addr = {4'd0, 4'd13, 4'd14};
    @(negedge clk); @(negedge clk);
    model_reset();
    rst = 0;
    tick(); #3;
    n_tests++; if (r_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", r_pc); end
    n_tests++; if (rdp(0) !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_lr got %h want ffffffff", rdp(0)); end
    n_tests++; if (r_ipsr !== 6'h3F) begin n_fail++; $display("FAIL reset_ipsr got %h want 3f", r_ipsr); end
    n_tests++; if (r_apsr !== 4'h0 || r_pm !== 1'b0) begin n_fail++; $display("FAIL reset_apsr_pm got %h/%b want 0/0", r_apsr, r_pm); end
    n_tests++; if (r_sp !== 32'h0 || rdp(1) !== 32'h0) begin n_fail++; $display("FAIL reset_sp got %h/%h want 0", r_sp, rdp(1)); end
    n_tests++;
    if ({seq_busy, seq_valid, seq_done} !== 3'b000 || seq_count !== 5'd0 || seq_idx !== 4'd0 || seq_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_seq got busy%b valid%b done%b cnt%0d want all 0", seq_busy, seq_valid, seq_done, seq_count);
    end
  endtask

  task automatic test_write_priority();
    wa_en = 1; wa_addr = 3; wa_data = 5; wb_en = 1; wb_addr = 3; wb_data = 9;
    tick(); idle(); rd_addr = {4'd3, 4'd3, 4'd3}; #3;
    for (int k = 0; k < NRD; k++) begin
      n_tests++; if (rdp(k) !== 32'd9) begin n_fail++; $display("FAIL ab_same_addr port%0d got %0d want 9", k, rdp(k)); end
    end
  endtask

  task automatic test_sp_bank();
    sp_sel = 0; wa_en = 1; wa_addr = 13; wa_data = 32'h2000_0003;
    tick(); idle(); rd_addr = {4'd13, 4'd0, 4'd0}; #3;
    n_tests++; if (r_sp !== 32'h2000_0000 || rdp(2) !== 32'h2000_0000) begin n_fail++; $display("FAIL msp_write got %h/%h want 20000000", r_sp, rdp(2)); end
    sp_sel = 1; #1;
    n_tests++; if (r_sp !== 32'h0 || rdp(2) !== 32'h0) begin n_fail++; $display("FAIL psp_select got %h/%h want 0", r_sp, rdp(2)); end
    wb_en = 1; wb_addr = 13; wb_data = 32'h1234_5677;
    tick(); idle(); #3;
    n_tests++; if (r_sp !== 32'h1234_5674) begin n_fail++; $display("FAIL psp_write got %h want 12345674", r_sp); end
    sp_sel = 0; #1;
    n_tests++; if (r_sp !== 32'h2000_0000) begin n_fail++; $display("FAIL msp_kept got %h want 20000000", r_sp); end
  endtask

  task automatic test_pc_priority();
    logic [DW-1:0] want [3];
    want[0] = 32'd100; want[1] = 32'd200; want[2] = 32'd300;
    for (int c = 0; c < 3; c++) begin
      pc_ld = (c == 0); pc_w = 32'd100;
      wb_en = (c <= 1); wb_addr = 15; wb_data = 32'd200;
      wa_en = 1;        wa_addr = 15; wa_data = 32'd300;
      tick(); idle(); rd_addr = {4'd0, 4'd0, 4'd15}; #3;
      n_tests++;
      if (r_pc !== want[c] || rdp(0) !== want[c]) begin
        n_fail++; $display("FAIL pc_priority case%0d got %0d/%0d want %0d", c, r_pc, rdp(0), want[c]);
      end
    end
  endtask

  task automatic test_status();
    for (int i = 0; i < 40; i++) begin
      apsr_ld = 1'($urandom); apsr_w = 4'($urandom);
      ipsr_ld = 1'($urandom); ipsr_w = 6'($urandom);
      pm_ld   = 1'($urandom); pm_w   = 1'($urandom);
      tick(); idle(); #3;
      n_tests++;
      if (r_apsr !== m_apsr || r_ipsr !== m_ipsr || r_pm !== m_pm) begin
        n_fail++; $display("FAIL status it%0d got %h/%h/%b want %h/%h/%b", i, r_apsr, r_ipsr, r_pm, m_apsr, m_ipsr, m_pm);
      end
    end
  endtask

  task automatic test_random_rw();
    for (int i = 0; i < 300; i++) begin
      wa_en = 1'($urandom); wa_addr = 4'($urandom); wa_data = $urandom;
      wb_en = 1'($urandom); wb_addr = ($urandom_range(0, 3) == 0) ? wa_addr : 4'($urandom); wb_data = $urandom;
      pc_ld = ($urandom_range(0, 7) == 0); pc_w = $urandom;
      sp_sel = 1'($urandom); rd_addr = 12'($urandom);
      #3;
      for (int k = 0; k < NRD; k++) begin
        n_tests++;
        if (rdp(k) !== m_expect(int'(rd_addr[k*AW +: AW]))) begin
          n_fail++; $display("FAIL rand_read it%0d port%0d addr%0d got %h want %h", i, k, rd_addr[k*AW +: AW], rdp(k), m_expect(int'(rd_addr[k*AW +: AW])));
        end
      end
      n_tests++;
      if (r_pc !== m_gpr[15] || r_sp !== m_sp[sp_sel]) begin
        n_fail++; $display("FAIL rand_pc_sp it%0d got %h/%h want %h/%h", i, r_pc, r_sp, m_gpr[15], m_sp[sp_sel]);
      end
      tick();
    end
    idle();
  endtask

  task automatic run_seq(input logic [NR-1:0] list, input bit rand_ready, input bit poke, output int done_cyc);
    int exp_q[$], got_q[$];
    int done_cnt = 0, cyc = 0, pc = 0;
    bit fin = 0;
    done_cyc = -1;
    for (int i = 0; i < NR; i++) if (list[i]) begin exp_q.push_back(i); pc++; end
    seq_list = list; seq_start = 1; tick(); seq_start = 0; seq_list = NR'($urandom);
    while (!fin && cyc < 60) begin
      seq_ready = rand_ready ? 1'($urandom) : (cyc % 2 == 0);
      seq_start = poke && (cyc == 1);
      #3;
      if (seq_busy) begin
        n_tests++; if (seq_count !== 5'(pc)) begin n_fail++; $display("FAIL seq_count got %0d want %0d", seq_count, pc); end
      end
      if (seq_valid) begin
        n_tests++;
        if (seq_data !== m_expect(int'(seq_idx))) begin
          n_fail++; $display("FAIL seq_data idx%0d got %h want %h", seq_idx, seq_data, m_expect(int'(seq_idx)));
        end
        if (seq_ready) got_q.push_back(int'(seq_idx));
      end
      if (seq_done) begin
        done_cnt++; fin = 1; done_cyc = cyc;
        n_tests++; if (seq_valid !== 1'b0) begin n_fail++; $display("FAIL seq_valid_in_done got %b want 0", seq_valid); end
      end
      tick(); cyc++;
    end
    seq_start = 0; seq_ready = 0; #3;
    n_tests++; if (!fin) begin n_fail++; $display("FAIL seq_timeout list %h got no done want done", list); end
    n_tests++; if (seq_done !== 1'b0 || seq_busy !== 1'b0) begin n_fail++; $display("FAIL seq_done_len got done%b busy%b want 0/0", seq_done, seq_busy); end
    n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL seq_done_count got %0d want 1", done_cnt); end
    n_tests++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL seq_beat_count list %h got %0d want %0d", list, got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++)
        if (got_q[i] != exp_q[i]) begin
          n_fail++; $display("FAIL seq_beat_order beat%0d got %0d want %0d", i, got_q[i], exp_q[i]); break;
        end
    end
  endtask

  task automatic test_seq_list();
    int dc;
    for (int i = 0; i < NR; i++) if (i != 13 && i != 15) begin
      wa_en = 1; wa_addr = 4'(i); wa_data = $urandom; tick();
    end
    idle();
    run_seq(16'h400A, 0, 1, dc);
  endtask

  task automatic test_seq_empty();
    int dc;
    run_seq(16'h0000, 0, 0, dc);
    n_tests++; if (dc != 0) begin n_fail++; $display("FAIL seq_empty_done_cycle got %0d want 0", dc); end
  endtask

  task automatic test_seq_random();
    int dc;
    for (int r = 0; r < 6; r++) begin
      sp_sel = 1'($urandom);
      run_seq(NR'($urandom), 1, 1'($urandom), dc);
    end
  endtask

  task automatic test_seq_reset();
    seq_list = 16'hF0F0; seq_start = 1; seq_ready = 1; tick(); seq_start = 0;
    tick(); #3;
    n_tests++; if (seq_valid !== 1'b1 || seq_idx !== 4'd5) begin n_fail++; $display("FAIL seq_second_beat got v%b idx%0d want v1 idx5", seq_valid, seq_idx); end
    rst = 1; #1;
    model_reset();
    n_tests++;
    if ({seq_busy, seq_valid, seq_done} !== 3'b000 || seq_idx !== 4'd0 || seq_count !== 5'd0) begin
      n_fail++; $display("FAIL seq_async_rst got busy%b valid%b done%b idx%0d cnt%0d want 0", seq_busy, seq_valid, seq_done, seq_idx, seq_count);
    end
    #2; rst = 0;
    tick(); #3;
    n_tests++; if (seq_busy !== 1'b0 || seq_valid !== 1'b0) begin n_fail++; $display("FAIL seq_after_rst got busy%b valid%b want 0/0", seq_busy, seq_valid); end
    seq_ready = 0;
  endtask

  task automatic test_bypass();
    logic [DW-1:0] want;
    wa_en = 1; wa_addr = 1; wa_data = 32'h11; tick(); idle();
    wa_en = 1; wa_addr = 1; wa_data = 32'd7; rd_addr = {4'd0, 4'd1, 4'd0}; #3;
`ifdef REGFILE_BYPASS_EN
    want = 32'd7;
`else
    want = 32'h11;
`endif
    n_tests++; if (rdp(1) !== want) begin n_fail++; $display("FAIL bypass_same_cycle got %h want %h", rdp(1), want); end
    tick(); idle(); #3;
    n_tests++; if (rdp(1) !== 32'd7) begin n_fail++; $display("FAIL bypass_after_edge got %h want 7", rdp(1)); end
  endtask

  initial begin
    idle();
    rst = 1; sp_sel = 0; rd_addr = '0;
    seq_start = 0; seq_list = '0; seq_ready = 0;
    model_reset();
    test_reset();
    test_write_priority();
    test_sp_bank();
    test_pc_priority();
    test_status();
    test_random_rw();
    test_seq_list();
    test_seq_empty();
    test_seq_random();
    test_seq_reset();
    test_bypass();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
